// File: rtl/trng_word_packer.sv
// trng_word_packer
//   Back end of the TRNG core. Samples the raw random_bit stream on a divided
//   strobe, runs a repetition-count health test (RCT) on every raw sample,
//   discards a warm-up window after enable, and packs accepted bits LSB-first
//   into WORD_W-bit words presented on a valid/ready interface. Also owns the
//   oscillator enable and sequences IDLE -> WARMUP -> COLLECT, with FAULT as a
//   sticky trap that only enable=0 or rst releases.
//
//   Build option: define TRNG_VON_NEUMANN_EN to debias COLLECT samples with a
//   Von Neumann corrector (pairs 01 -> 0, 10 -> 1, 00/11 discarded). The RCT
//   always sees the raw samples.
//
//   Timing: the strobe sample is registered once (smp_vld_q/smp_bit_q) before
//   the RCT, warm-up counter and packer consume it, and a complete word moves
//   to the output register one cycle after it completes. At defaults the first
//   word is therefore valid 386 cycles after enable is sampled.

module trng_word_packer #(
  parameter int WORD_W      = 32,
  parameter int SAMPLE_DIV  = 4,
  parameter int WARMUP_BITS = 64,
  parameter int RCT_LIMIT   = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              random_bit,
  output logic              osc_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  output logic              warmup_done
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RUN_W  = $clog2(RCT_LIMIT + 1);
  localparam int WARM_W = $clog2(WARMUP_BITS + 1);
  localparam int CNT_W  = $clog2(WORD_W + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(RCT_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_W);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_FAULT   = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic              smp_vld_q,  smp_vld_d;
  logic              smp_bit_q,  smp_bit_d;
  logic [RUN_W-1:0]  run_len_q,  run_len_d;
  logic              last_bit_q, last_bit_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [WORD_W-1:0] asm_q,      asm_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic active;     // oscillators running, divider and RCT live
  logic strobe;     // raw sample taken this cycle
  logic rct_trip;   // run length has hit the limit
  logic word_full;  // assembly register holds a complete word
  logic can_load;   // output slot free or being freed this cycle
  logic xfer;       // assembly -> output register this cycle
  logic warm_done;  // last warm-up sample is being consumed
  logic acc_vld;    // a bit is accepted into the assembly register
  logic acc_bit;

  assign active    = (state_q == S_WARMUP) || (state_q == S_COLLECT);
  assign strobe    = active && (div_q == DIV_LAST);
  assign rct_trip  = active && (run_len_q >= RUN_MAX);
  assign word_full = (bit_cnt_q == CNT_FULL);
  assign can_load  = !out_valid_q || out_ready;
  // A trip or a software stop in the same cycle wins over the transfer.
  assign xfer      = (state_q == S_COLLECT) && word_full && can_load &&
                     !rct_trip && enable;
  assign warm_done = (state_q == S_WARMUP) && smp_vld_q && (warm_cnt_q == WARM_LAST);

`ifdef TRNG_VON_NEUMANN_EN
  logic pair_ph_q,    pair_ph_d;     // 1: first half of a pair captured
  logic pair_first_q, pair_first_d;

  // Von Neumann corrector: decide which COLLECT samples become packed bits.
  always_comb begin
    acc_vld      = 1'b0;
    acc_bit      = 1'b0;
    pair_ph_d    = pair_ph_q;
    pair_first_d = pair_first_q;
    if (state_q != S_COLLECT) begin
      // Pairing always starts fresh on entry to COLLECT.
      pair_ph_d = 1'b0;
    end else if (smp_vld_q) begin
      if (word_full) begin
        // Sample dropped while the output slot is busy; re-align pairs.
        pair_ph_d = 1'b0;
      end else if (!pair_ph_q) begin
        pair_first_d = smp_bit_q;
        pair_ph_d    = 1'b1;
      end else begin
        pair_ph_d = 1'b0;
        acc_vld   = (pair_first_q != smp_bit_q);
        acc_bit   = pair_first_q;
      end
    end
  end

  // Corrector pair state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_ph_q    <= 1'b0;
      pair_first_q <= 1'b0;
    end else begin
      pair_ph_q    <= pair_ph_d;
      pair_first_q <= pair_first_d;
    end
  end
`else
  // Direct path: every COLLECT sample that finds room is packed.
  always_comb begin
    acc_vld = (state_q == S_COLLECT) && smp_vld_q && !word_full;
    acc_bit = smp_bit_q;
  end
`endif

  // Next-state logic for sequencer, divider, RCT, packer and output slot.
  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed default) so no path through this block can infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    smp_vld_d   = strobe;
    smp_bit_d   = strobe ? random_bit : smp_bit_q;
    run_len_d   = run_len_q;
    last_bit_d  = last_bit_q;
    warm_cnt_d  = warm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;

    // Free-running sample divider while the oscillators run.
    if (active) begin
      div_d = strobe ? '0 : div_q + 1'b1;
    end

    // Repetition-count test on every raw sample, saturating at the limit.
    if (active && smp_vld_q) begin
      if ((run_len_q == '0) || (smp_bit_q != last_bit_q)) begin
        run_len_d = RUN_ONE;
      end else if (run_len_q != RUN_MAX) begin
        run_len_d = run_len_q + 1'b1;
      end
      last_bit_d = smp_bit_q;
    end

    // Warm-up discard counter.
    if ((state_q == S_WARMUP) && smp_vld_q && !warm_done) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
    end

    // Packer: bit i of the word is the i-th accepted bit.
    if (acc_vld) begin
      asm_d     = asm_q | (WORD_W'(acc_bit) << bit_cnt_q);
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Output slot refill (also covers accept-and-refill in one cycle).
    if (xfer) begin
      out_data_d  = asm_q;
      out_valid_d = 1'b1;
      asm_d       = '0;
      bit_cnt_d   = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_WARMUP;
          div_d      = '0;
          smp_vld_d  = 1'b0;
          run_len_d  = '0;
          last_bit_d = 1'b0;
          warm_cnt_d = '0;
        end
      end
      S_WARMUP: begin
        if (rct_trip) begin
          state_d = S_FAULT;
        end else if (warm_done) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (rct_trip) begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = state_q;  // FAULT holds until enable drops
      end
    endcase

    // Fault entry: stop sampling and throw away the partial (or complete)
    // assembly word; a word already in the output slot stays valid.
    if (rct_trip) begin
      div_d     = '0;
      smp_vld_d = 1'b0;
      asm_d     = '0;
      bit_cnt_d = '0;
    end

    // Software stop dominates everything except rst.
    if (!enable && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      div_d       = '0;
      smp_vld_d   = 1'b0;
      run_len_d   = '0;
      last_bit_d  = 1'b0;
      warm_cnt_d  = '0;
      bit_cnt_d   = '0;
      asm_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      smp_vld_q   <= 1'b0;
      smp_bit_q   <= 1'b0;
      run_len_q   <= '0;
      last_bit_q  <= 1'b0;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      div_q       <= div_d;
      smp_vld_q   <= smp_vld_d;
      smp_bit_q   <= smp_bit_d;
      run_len_q   <= run_len_d;
      last_bit_q  <= last_bit_d;
      warm_cnt_q  <= warm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs decode straight from registered state.
  assign osc_en      = active;
  assign warmup_done = (state_q == S_COLLECT);
  assign health_fail = (state_q == S_FAULT);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_trng_word_packer.sv
// Self-checking bench for trng_word_packer (default parameters).
// random_bit is driven per strobe window from a pattern table pat[]; expected
// words are derived from pat[] and queued before each run, then popped and
// compared whenever the DUT completes a valid/ready handshake.
// Works with or without TRNG_VON_NEUMANN_EN defined.

module tb_trng_word_packer;

  localparam int WORD_W      = 32;
  localparam int SAMPLE_DIV  = 4;
  localparam int WARMUP_BITS = 64;
  localparam int RCT_LIMIT   = 34;
  localparam int NPAT        = 2048;
`ifdef TRNG_VON_NEUMANN_EN
  localparam int ALT_COLLECT = 2 * WORD_W;       // alternating input: one bit per pair
  localparam logic [WORD_W-1:0] ALT_WORD = 32'h0000_0000;
`else
  localparam int ALT_COLLECT = WORD_W;
  localparam logic [WORD_W-1:0] ALT_WORD = 32'hAAAA_AAAA;
`endif
  localparam int FIRST_LAT = 1 + SAMPLE_DIV * (WARMUP_BITS + ALT_COLLECT) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              random_bit;
  logic              osc_en;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              health_fail;
  logic              warmup_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since the edge that sampled enable=1
  int cur    = 0;   // cycle index of the current observation point
  int hs_cnt = 0;
  bit pat [NPAT];
  logic [WORD_W-1:0] sb_q [$];

  trng_word_packer #(
    .WORD_W(WORD_W), .SAMPLE_DIV(SAMPLE_DIV),
    .WARMUP_BITS(WARMUP_BITS), .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
    .osc_en(osc_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .health_fail(health_fail), .warmup_done(warmup_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: a word is taken at the next edge when valid && ready.
  task automatic mon();
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (sb_q.size() == 0) check("sb_unexpected_word", sb_q.size(), 1);
      else                  check("word", out_data, sb_q.pop_front());
    end
  endtask

  // One cycle: observe at the falling edge, then drive the next raw bit.
  task automatic step();
    int idx;
    @(negedge clk);
    cur = cyc;
    mon();
    idx = cyc / SAMPLE_DIV;
    if (idx >= NPAT) idx = NPAT - 1;
    random_bit = pat[idx];
    cyc++;
  endtask

  // Called at a falling edge with the DUT idle: next rising edge is cycle 0.
  task automatic begin_run();
    enable     = 1'b1;
    cyc        = 0;
    random_bit = pat[0];
  endtask

  task automatic fill_alt(input bit phase);
    for (int k = 0; k < NPAT; k++) pat[k] = bit'(k & 1) ^ phase;
  endtask

  // Random bits with runs capped well below the RCT limit.
  task automatic fill_random();
    int run = 1;
    pat[0] = bit'($urandom_range(0, 1));
    for (int k = 1; k < NPAT; k++) begin
      pat[k] = bit'($urandom_range(0, 1));
      run = (pat[k] == pat[k-1]) ? run + 1 : 1;
      if (run >= 20) begin pat[k] = ~pat[k-1]; run = 1; end
    end
  endtask

  // Index of the strobe whose sample makes the run reach RCT_LIMIT.
  function automatic int trip_strobe();
    int run = 1;
    for (int k = 1; k < NPAT; k++) begin
      run = (pat[k] == pat[k-1]) ? run + 1 : 1;
      if (run >= RCT_LIMIT) return k;
    end
    return NPAT;
  endfunction

  // Reference packer: words formed from COLLECT strobes (WARMUP_BITS onward),
  // assuming no backpressure drops; words completing at/after stop_k are lost.
  task automatic push_words(input int n, input int stop_k);
    logic [WORD_W-1:0] w = '0;
    int bc = 0, made = 0, last = 0, k = WARMUP_BITS;
    while (made < n && k < NPAT - 1) begin
`ifdef TRNG_VON_NEUMANN_EN
      last = k + 1;
      if (pat[k] != pat[k+1]) begin w[bc] = pat[k]; bc++; end
      k += 2;
`else
      last = k;
      w[bc] = pat[k]; bc++;
      k++;
`endif
      if (bc == WORD_W) begin
        if (last >= stop_k) break;
        sb_q.push_back(w);
        made++; w = '0; bc = 0;
      end
    end
  endtask

  initial begin
    int first, bad, hs0, exp_fault, tk;
    bit saw_valid;
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1; random_bit = 1'b0;

    // Reset with enable asserted: everything stays quiet.
    repeat (3) @(negedge clk);
    check("rst_osc_en", osc_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_health_fail", health_fail, 0);
    check("rst_warmup_done", warmup_done, 0);

    // T1: alternating stream, release reset with enable held -> first word latency.
    fill_alt(1'b0);
    push_words(1, trip_strobe());
    rst = 1'b0; cyc = 0; random_bit = pat[0];
    first = -1;
    for (int i = 0; i < 700 && first < 0; i++) begin
      step();
      if (cur == 100) begin
        check("t1_osc_en_warmup", osc_en, 1);
        check("t1_warmup_done_low", warmup_done, 0);
      end
      if (cur == 300) check("t1_warmup_done_high", warmup_done, 1);
      if (out_valid) begin
        first = cur;
        check("t1_word_value", out_data, ALT_WORD);
      end
    end
    check("t1_latency", first, FIRST_LAT);
    enable = 1'b0;
    step();
    check("t1_stop_valid", out_valid, 0);
    check("t1_stop_osc", osc_en, 0);
    step();

    // T2: stuck-at-1 stream -> RCT fault, no output, enable=0 clears.
    for (int k = 0; k < NPAT; k++) pat[k] = 1'b1;
    exp_fault = SAMPLE_DIV * (trip_strobe() + 1) + 2;
    begin_run();
    first = -1; saw_valid = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (out_valid) saw_valid = 1;
      if (health_fail && first < 0) begin
        first = cur;
        check("t2_osc_off", osc_en, 0);
      end
    end
    check("t2_fault_cycle", first, exp_fault);
    check("t2_no_valid", saw_valid, 0);
    enable = 1'b0;
    step();
    check("t2_hf_cleared", health_fail, 0);
    step();

    // T3: backpressure; first word must hold for 1000 cycles, then refill on accept.
    fill_random();
    out_ready = 1'b0;
    push_words(2, trip_strobe());
    begin_run();
    first = -1;
    for (int i = 0; i < 2000 && first < 0; i++) begin
      step();
      if (out_valid) first = cur;
    end
    check("t3_first_seen", first >= 0, 1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!out_valid || out_data !== sb_q[0]) bad++;
    end
    check("t3_hold_stable", bad, 0);
    out_ready = 1'b1;
    mon();        // word 1 accepted at the coming edge
    step();       // word 2 must be in the slot now (and is accepted here)
    check("t3_valid_refill", out_valid, 1);
    enable = 1'b0;
    step();
    check("t3_stop_valid", out_valid, 0);
    check("t3_sb_drained", sb_q.size(), 0);
    step();

    // T4: enable drop with 17 bits assembled, then full warm-up again.
    fill_alt(1'b0);
    begin_run();
    saw_valid = 0;
    while (cyc <= 326) begin
      step();
      if (out_valid) saw_valid = 1;
    end
    enable = 1'b0;
    step();
    check("t4_idle_osc", osc_en, 0);
    check("t4_idle_valid", out_valid | saw_valid, 0);
    check("t4_idle_wd", warmup_done, 0);
    step();
    push_words(1, trip_strobe());
    begin_run();
    first = -1;
    for (int i = 0; i < 700 && first < 0; i++) begin
      step();
      if (out_valid) first = cur;
    end
    check("t4_relatency", first, FIRST_LAT);
    enable = 1'b0;
    step();
    step();

    // T5: RCT trips on the strobe that completes word 2 while word 1 waits.
    for (int k = 0; k < NPAT; k++) pat[k] = (k < 94) ? bit'((k + 1) & 1) : 1'b1;
    tk = trip_strobe();
    exp_fault = SAMPLE_DIV * (tk + 1) + 2;
    out_ready = 1'b0;
    hs0 = sb_q.size();
    push_words(1, tk);
    hs0 = sb_q.size() - hs0;
    begin_run();
    first = -1;
    for (int i = 0; i < 700 && first < 0; i++) begin
      step();
      if (health_fail) first = cur;
    end
    check("t5_fault_cycle", first, exp_fault);
    check("t5_valid_held", out_valid, hs0 > 0);
`ifndef TRNG_VON_NEUMANN_EN
    check("t5_held_word", out_data, 32'hD555_5555);
`endif
    out_ready = 1'b1;
    mon();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (out_valid || !health_fail) bad++;
    end
    check("t5_no_second_word", bad, 0);
    check("t5_sb_drained", sb_q.size(), 0);
    enable = 1'b0;
    step();
    step();

    // T6: random stream, three consecutive words with out_ready held high.
    fill_random();
    push_words(3, trip_strobe());
    begin_run();
    hs0 = hs_cnt;
    for (int i = 0; i < 4000 && (hs_cnt - hs0) < 3; i++) step();
    check("t6_word_count", hs_cnt - hs0, 3);
    enable = 1'b0;
    step();
    check("t6_stop_valid", out_valid, 0);

    check("final_sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
